pipe_skid_reg: RTL and testbench
================================

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, width of the datapath payload (ALU result, store data, destination register, concatenated).
REQ-002 The block SHALL have parameter CTRL_W, default 4, width of the control-bit vector (MemtoReg, RegWrite, MemRead, MemWrite).
REQ-003 The block SHALL have parameter CNT_W, default 16, width of the stall counter.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-006 The block SHALL have port flush, input, 1, synchronous discard of all held entries.
REQ-007 The block SHALL have port in_valid, input, 1, upstream entry present.
REQ-008 The block SHALL have port in_ready, output, 1, block can accept this cycle.
REQ-009 The block SHALL have port in_ctrl, input, CTRL_W, upstream control bits.
REQ-010 The block SHALL have port in_data, input, DATA_W, upstream payload.
REQ-011 The block SHALL have port out_valid, output, 1, entry presented downstream.
REQ-012 The block SHALL have port out_ready, input, 1, downstream accepts.
REQ-013 The block SHALL have port out_ctrl, output, CTRL_W, presented control bits.
REQ-014 The block SHALL have port out_data, output, DATA_W, presented payload.
REQ-015 The block SHALL have port occupancy, output, 2, entries held (0..2).
REQ-016 The block SHALL have port stall_cnt, output, CNT_W, count of back-pressured cycles.

Function
REQ-017 The block SHALL implement a 2-entry skid buffer (main register driving the outputs, plus a skid register) with states EMPTY, ONE and TWO.
REQ-018 Input transfer SHALL occur when in_valid and in_ready are both 1; output transfer SHALL occur when out_valid and out_ready are both 1.
REQ-019 in_ready SHALL be a registered output, 1 exactly when the state is not TWO, with no combinational path from out_ready.
REQ-020 out_valid SHALL be 1 exactly when the state is ONE or TWO; occupancy SHALL equal 0, 1 or 2 for EMPTY, ONE or TWO respectively.
REQ-021 In EMPTY, an input transfer SHALL load the main register and move to ONE; otherwise the block stays in EMPTY.
REQ-022 In ONE, input and output transfers together SHALL load main from the input and stay in ONE.
REQ-023 In ONE, an input transfer alone SHALL load skid and move to TWO.
REQ-024 In ONE, an output transfer alone SHALL move to EMPTY.
REQ-025 In TWO, an output transfer SHALL move skid into main and go to ONE; otherwise the block stays in TWO (no input is possible).
REQ-026 Latency SHALL be 1 cycle: an input accepted in cycle N while EMPTY is presented with out_valid=1 in cycle N+1.
REQ-027 Entry order SHALL be strictly preserved, with no duplication or loss except by flush or reset.
REQ-028 out_ctrl SHALL be all-zero whenever out_valid=0 (bubble semantics), so no RegWrite or MemWrite leaks from an empty stage.
REQ-029 out_data SHALL hold its last value when the block goes empty; only reset zeroes it.
REQ-030 flush=1 SHALL force EMPTY, zero the held ctrl registers and discard any input offered that cycle; an output transfer in the flush cycle counts as completed.
REQ-031 stall_cnt SHALL increment by 1 in each cycle with out_valid=1 and out_ready=0, saturate at 2^CNT_W-1 and be unaffected by flush.

Reset
REQ-032 Reset SHALL set the state to EMPTY and give out_valid=0, in_ready=1, occupancy=0, out_ctrl=0, out_data=0, stall_cnt=0, with the skid registers also zeroed.
REQ-033 Reset SHALL take priority over flush and all transfers, including when asserted mid-operation in TWO.
REQ-034 in_ready SHALL be 1 in the first cycle after rst deasserts.

Structure
REQ-035 Package pipe_pkg SHALL hold the state enum (EMPTY, ONE, TWO) and the default width constants (32, 4, 16).
REQ-036 The saturating stall counter SHALL be the single sub-module, named pipe_sat_counter, with parameter CNT_W and ports clk, rst, inc, count.
REQ-037 Existing fixed stage registers SHALL map to this block with CTRL_W=4 and DATA_W=69 (32+32+5).

Verification
REQ-038 Pass-through: out_ready=1, drive entries A=0x11, B=0x22 on consecutive cycles -> out_data shows 0x11 then 0x22 one cycle later, occupancy stays at 1 or below.
REQ-039 Back-pressure: out_ready=0, offer 3 entries -> 2 accepted, in_ready=0 from the cycle after the second, occupancy=2; release out_ready -> outputs in order, then in_ready=1.
REQ-040 Flush: state TWO, flush=1 with in_valid=1 -> next cycle occupancy=0, out_valid=0, out_ctrl=0, and the offered entry never appears.
REQ-041 Stall saturation: CNT_W=3, out_valid=1, out_ready=0 for 10 cycles -> stall_cnt reads 1..7 then holds at 7.
REQ-042 Reset mid-operation: state TWO with stall_cnt=5, rst=1 for one cycle -> all outputs at their reset values next cycle, in_ready=1.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and default widths for the pipeline skid register and its helpers.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } skid_state_t;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_CTRL_W = 4;
    localparam int DEF_CNT_W  = 16;

    // EX/MEM stage payload: ALU result, store data and destination register.
    localparam int EXMEM_DATA_W = 32 + 32 + 5;

    function automatic logic [1:0] occupancy_of(input skid_state_t st);
        case (st)
            ONE:     occupancy_of = 2'd1;
            TWO:     occupancy_of = 2'd2;
            default: occupancy_of = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter: counts cycles with inc=1 and sticks at its maximum value.
module pipe_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_STEP = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (inc && (r_count != '1)) begin
            r_count <= r_count + CNT_STEP;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/pipe_skid_reg.sv
// Two-entry skid buffer used as a pipeline stage register with flush, bubble
// gating of control bits and a back-pressure cycle counter.
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CTRL_W = DEF_CTRL_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    // Handshake: a transfer happens on a side in any cycle where valid and ready
    // are both 1; in_ready comes from a register so out_ready never reaches it.
    skid_state_t       r_state;
    skid_state_t       w_next_state;
    logic              r_in_ready;
    logic [CTRL_W-1:0] r_main_ctrl;
    logic [DATA_W-1:0] r_main_data;
    logic [CTRL_W-1:0] r_skid_ctrl;
    logic [DATA_W-1:0] r_skid_data;

    logic w_out_valid;
    logic w_in_xfer;
    logic w_out_xfer;
    logic w_load_main;
    logic w_load_skid;
    logic w_skid_to_main;

    assign w_out_valid = (r_state != EMPTY);
    assign w_in_xfer   = in_valid & r_in_ready;
    assign w_out_xfer  = w_out_valid & out_ready;

    always_comb begin
        w_next_state   = r_state;
        w_load_main    = 1'b0;
        w_load_skid    = 1'b0;
        w_skid_to_main = 1'b0;
        case (r_state)
            EMPTY: begin
                if (w_in_xfer) begin
                    w_load_main  = 1'b1;
                    w_next_state = ONE;
                end
            end
            ONE: begin
                if (w_in_xfer && w_out_xfer) begin
                    w_load_main = 1'b1;
                end else if (w_in_xfer) begin
                    w_load_skid  = 1'b1;
                    w_next_state = TWO;
                end else if (w_out_xfer) begin
                    w_next_state = EMPTY;
                end
            end
            TWO: begin
                if (w_out_xfer) begin
                    w_skid_to_main = 1'b1;
                    w_next_state   = ONE;
                end
            end
            default: w_next_state = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= EMPTY;
            r_in_ready  <= 1'b1;
            r_main_ctrl <= '0;
            r_main_data <= '0;
            r_skid_ctrl <= '0;
            r_skid_data <= '0;
        end else if (flush) begin
            // Data registers keep their contents so out_data stays stable.
            r_state     <= EMPTY;
            r_in_ready  <= 1'b1;
            r_main_ctrl <= '0;
            r_skid_ctrl <= '0;
        end else begin
            r_state    <= w_next_state;
            r_in_ready <= (w_next_state != TWO);
            if (w_load_main) begin
                r_main_ctrl <= in_ctrl;
                r_main_data <= in_data;
            end else if (w_skid_to_main) begin
                r_main_ctrl <= r_skid_ctrl;
                r_main_data <= r_skid_data;
            end
            if (w_load_skid) begin
                r_skid_ctrl <= in_ctrl;
                r_skid_data <= in_data;
            end
        end
    end

    pipe_sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_out_valid & ~out_ready),
        .count (stall_cnt)
    );

    assign in_ready  = r_in_ready;
    assign out_valid = w_out_valid;
    assign out_ctrl  = w_out_valid ? r_main_ctrl : '0;
    assign out_data  = r_main_data;
    assign occupancy = occupancy_of(r_state);

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_pipe_skid_reg;

    localparam int DW   = 32;
    localparam int CW   = 4;
    localparam int CNTW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [CW-1:0]   in_ctrl, out_ctrl;
    logic [DW-1:0]   in_data, out_data;
    logic [1:0]      occupancy;
    logic [CNTW-1:0] stall_cnt;

    logic            s_rst, s_flush, s_in_valid, s_in_ready, s_out_valid, s_out_ready;
    logic [3:0]      s_in_ctrl, s_out_ctrl;
    logic [7:0]      s_in_data, s_out_data;
    logic [1:0]      s_occupancy;
    logic [2:0]      s_stall_cnt;

    pipe_skid_reg #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(CNTW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
        .occupancy(occupancy), .stall_cnt(stall_cnt)
    );

    pipe_skid_reg #(.DATA_W(8), .CTRL_W(4), .CNT_W(3)) dut_sat (
        .clk(clk), .rst(s_rst), .flush(s_flush),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_ctrl(s_in_ctrl), .in_data(s_in_data),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_ctrl(s_out_ctrl), .out_data(s_out_data),
        .occupancy(s_occupancy), .stall_cnt(s_stall_cnt)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: the held entries in order, oldest first.
    logic [CW+DW-1:0] exp_q[$];
    logic [DW-1:0]    m_out_data;
    logic [CNTW-1:0]  m_stall;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_update();
        bit ox, ix;
        if (rst) begin
            exp_q.delete();
            m_out_data = '0;
            m_stall    = '0;
        end else begin
            ox = (exp_q.size() > 0) && out_ready;
            ix = in_valid && (exp_q.size() < 2);
            if ((exp_q.size() > 0) && !out_ready && (m_stall != '1)) m_stall++;
            if (ox) void'(exp_q.pop_front());
            if (flush) exp_q.delete();
            else if (ix) exp_q.push_back({in_ctrl, in_data});
            if (exp_q.size() > 0) m_out_data = exp_q[0][DW-1:0];
        end
    endtask

    task automatic check_all();
        logic [CW-1:0] e_ctrl;
        e_ctrl = (exp_q.size() > 0) ? exp_q[0][CW+DW-1:DW] : '0;
        chk("m_out_valid", out_valid, exp_q.size() > 0);
        chk("m_in_ready", in_ready, exp_q.size() < 2);
        chk("m_occupancy", occupancy, exp_q.size());
        chk("m_out_ctrl", out_ctrl, e_ctrl);
        chk("m_out_data", out_data, m_out_data);
        chk("m_stall_cnt", stall_cnt, m_stall);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_update();
        @(negedge clk);
        check_all();
    endtask

    task automatic set_in(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d);
        in_valid = v;
        in_ctrl  = c;
        in_data  = d;
    endtask

    initial begin
        int thr;
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        set_in(1'b0, '0, '0);
        s_rst = 1'b1; s_flush = 1'b0; s_in_valid = 1'b0; s_in_ctrl = 4'h0;
        s_in_data = 8'h0; s_out_ready = 1'b0;
        @(negedge clk);

        // Reset values
        cycle();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_occ", occupancy, 0);
        chk("rst_out_ctrl", out_ctrl, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_stall", stall_cnt, 0);
        rst = 1'b0;
        cycle();
        chk("post_rst_in_ready", in_ready, 1);

        // Pass-through, one-cycle latency
        out_ready = 1'b1;
        set_in(1'b1, 4'h1, 32'h11);
        cycle();
        chk("pt_a_data", out_data, 32'h11);
        chk("pt_a_occ", occupancy, 1);
        set_in(1'b1, 4'h2, 32'h22);
        cycle();
        chk("pt_b_data", out_data, 32'h22);
        chk("pt_b_ctrl", out_ctrl, 4'h2);
        chk("pt_b_occ", occupancy, 1);
        set_in(1'b0, '0, '0);
        cycle();
        chk("pt_empty_valid", out_valid, 0);
        chk("pt_empty_ctrl", out_ctrl, 0);
        chk("pt_hold_data", out_data, 32'h22);

        // Back-pressure: third offer is refused
        out_ready = 1'b0;
        set_in(1'b1, 4'h3, 32'h31);
        cycle();
        chk("bp_1_ready", in_ready, 1);
        chk("bp_1_occ", occupancy, 1);
        set_in(1'b1, 4'h3, 32'h32);
        cycle();
        chk("bp_2_ready", in_ready, 0);
        chk("bp_2_occ", occupancy, 2);
        set_in(1'b1, 4'h3, 32'h33);
        cycle();
        chk("bp_3_occ", occupancy, 2);
        chk("bp_3_data", out_data, 32'h31);
        set_in(1'b0, '0, '0);
        out_ready = 1'b1;
        cycle();
        chk("bp_rel_data", out_data, 32'h32);
        chk("bp_rel_ready", in_ready, 1);
        cycle();
        chk("bp_drain_occ", occupancy, 0);

        // Flush from TWO discards the offered entry
        out_ready = 1'b0;
        set_in(1'b1, 4'h4, 32'h41);
        cycle();
        set_in(1'b1, 4'h4, 32'h42);
        cycle();
        chk("fl_pre_occ", occupancy, 2);
        flush = 1'b1;
        set_in(1'b1, 4'h5, 32'h99);
        cycle();
        chk("fl_occ", occupancy, 0);
        chk("fl_valid", out_valid, 0);
        chk("fl_ctrl", out_ctrl, 0);
        chk("fl_ready", in_ready, 1);
        flush = 1'b0;
        set_in(1'b0, '0, '0);
        out_ready = 1'b1;
        repeat (3) cycle();
        chk("fl_never_valid", out_valid, 0);

        // Reset mid-operation in TWO with stall_cnt=5
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        out_ready = 1'b0;
        set_in(1'b1, 4'h6, 32'h51);
        cycle();
        set_in(1'b1, 4'h6, 32'h52);
        cycle();
        set_in(1'b0, '0, '0);
        repeat (4) cycle();
        chk("rm_pre_stall", stall_cnt, 5);
        chk("rm_pre_occ", occupancy, 2);
        rst = 1'b1;
        flush = 1'b1;
        out_ready = 1'b1;
        set_in(1'b1, 4'h7, 32'h53);
        cycle();
        chk("rm_valid", out_valid, 0);
        chk("rm_ready", in_ready, 1);
        chk("rm_occ", occupancy, 0);
        chk("rm_ctrl", out_ctrl, 0);
        chk("rm_data", out_data, 0);
        chk("rm_stall", stall_cnt, 0);
        rst = 1'b0;
        flush = 1'b0;
        out_ready = 1'b0;
        set_in(1'b0, '0, '0);
        cycle();
        chk("rm_after_ready", in_ready, 1);

        // Saturation on the 3-bit counter instance
        s_rst = 1'b0;
        s_in_valid = 1'b1;
        s_in_ctrl = 4'h9;
        s_in_data = 8'hA5;
        cycle();
        s_in_valid = 1'b0;
        chk("sat_start", s_stall_cnt, 0);
        chk("sat_valid", s_out_valid, 1);
        for (int k = 1; k <= 10; k++) begin
            cycle();
            chk($sformatf("sat_%0d", k), s_stall_cnt, (k < 7) ? k : 7);
        end

        // Randomized traffic with varying downstream pressure
        thr = 50;
        for (int n = 0; n < 3000; n++) begin
            if ((n % 200) == 0) thr = $urandom_range(10, 95);
            rst       = ($urandom_range(0, 299) == 0);
            flush     = ($urandom_range(0, 15) == 0);
            out_ready = ($urandom_range(0, 99) < thr);
            set_in($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), $urandom);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
